if_id_reg: RTL

- Fetch-to-decode pipeline register of the five-stage MIPS core with precise exceptions.
- Sits directly downstream of the PC register and instruction memory.
- Captures the fetched PC/instruction, detects fetch-address exceptions (AdEL), tracks branch-delay-slot status, and inserts bubbles on interrupt/exception request or eret.
- Drives all D-stage consumers (decoder, hazard unit, CP0 exception pipeline).

---
 rtl/if_id_reg_pkg.sv | 22 ++
 rtl/if_id_reg_fetch_exc_check.sv | 15 +
 rtl/if_id_reg.sv | 64 ++++++
 3 files changed

// File: rtl/if_id_reg_pkg.sv
// Shared address map and exception codes for the fetch/decode/CP0 path.
// No logic of its own; the range check helper is used by F and M stage checkers.
package if_id_reg_pkg;

   localparam logic [31:0] PC_RESET   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] IM_LO      = 32'h0000_3000;
   localparam logic [31:0] IM_HI      = 32'h0000_6ffc;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   function automatic logic addr_out_of_range(input logic [31:0] addr,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
      return (addr < lo) || (addr > hi);
   endfunction

endpackage

// File: rtl/if_id_reg_fetch_exc_check.sv
// Combinational fetch-address checker: flags misaligned or out-of-map word addresses.
// Zero latency, no state; reusable by the M-stage load checker with its own bounds.
module if_id_reg_fetch_exc_check
   import if_id_reg_pkg::*;
#(
   parameter logic [31:0] LO = IM_LO,
   parameter logic [31:0] HI = IM_HI
) (
   input  logic [31:0] addr,
   output logic        exc
);

   assign exc = (addr[1:0] != 2'b00) || addr_out_of_range(addr, LO, HI);

endmodule

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with AdEL detection, delay-slot tracking and flush bubbles.
// Latency 1 cycle, registered outputs only; Stall holds everything, Req overrides Stall.
module if_id_reg
   import if_id_reg_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic        Req,
   input  logic        EretFlush,
   input  logic [31:0] F_PC,
   input  logic [31:0] F_Instr,
   input  logic        D_IsBranchJump,
   output logic [31:0] D_PC,
   output logic [31:0] D_Instr,
   output logic [4:0]  D_ExcCode,
   output logic        D_BD,
   output logic        D_Valid
);

   logic f_exc;

   if_id_reg_fetch_exc_check #(
      .LO (IM_LO),
      .HI (IM_HI)
   ) u_fetch_exc_check (
      .addr (F_PC),
      .exc  (f_exc)
   );

   // Req beats Stall so D stays in step with the PC register, which loads
   // the handler address regardless of Stall. A stalled eret stays in D and
   // re-asserts EretFlush once the stall clears.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         D_PC      <= PC_RESET;
         D_Instr   <= '0;
         D_ExcCode <= '0;
         D_BD      <= 1'b0;
         D_Valid   <= 1'b0;
      end else if (Req) begin
         D_PC      <= HANDLER_PC;
         D_Instr   <= '0;
         D_ExcCode <= '0;
         D_BD      <= 1'b0;
         D_Valid   <= 1'b0;
      end else if (!Stall) begin
         D_PC <= F_PC;
         if (EretFlush) begin
            D_Instr   <= '0;
            D_ExcCode <= '0;
            D_BD      <= 1'b0;
            D_Valid   <= 1'b0;
         end else begin
            // A faulted fetch stays valid so CP0 can take AdEL with EPC = D_PC.
            D_Instr   <= f_exc ? 32'h0 : F_Instr;
            D_ExcCode <= f_exc ? EXC_ADEL : 5'd0;
            D_BD      <= D_IsBranchJump;
            D_Valid   <= 1'b1;
         end
      end
   end

endmodule
